// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment driver.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}; anodes are active-low.
package seg7_pkg;

    // Digit position within a scan frame: 0/1 = seg1 units/tens, 2/3 = seg2 units/tens
    typedef logic [1:0] digit_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D3  = 4'b0111;

    // One-hot-low anode pattern for a digit position
    function automatic logic [3:0] an_select(input digit_t d);
        logic [3:0] pat;
        case (d)
            2'd0:    pat = AN_D0;
            2'd1:    pat = AN_D1;
            2'd2:    pat = AN_D2;
            default: pat = AN_D3;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low 7-segment glyph. 0xA is a dash, 0xB-0xF are blank,
// and a set suppress flag blanks the digit regardless of its value.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       suppress,
    output logic [6:0] cat
);

    // Glyph lookup with suppression override
    always_comb begin
        cat = SEG_BLANK;
        if (!suppress) begin
            case (nibble)
                4'h0:    cat = SEG_0;
                4'h1:    cat = SEG_1;
                4'h2:    cat = SEG_2;
                4'h3:    cat = SEG_3;
                4'h4:    cat = SEG_4;
                4'h5:    cat = SEG_5;
                4'h6:    cat = SEG_6;
                4'h7:    cat = SEG_7;
                4'h8:    cat = SEG_8;
                4'h9:    cat = SEG_9;
                4'hA:    cat = SEG_DASH;
                default: cat = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit time-multiplexed common-anode display driver for two packed-BCD
// counter outputs. Inputs are latched once per frame so a frame never mixes
// old and new values; each dwell starts with all anodes off to avoid ghosting.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_HZ      = 125000000,
    parameter int DIGIT_HZ    = 1000,
    parameter int DEAD_CYC    = 1250,
    parameter int BLINK_HZ    = 2,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg1,
    input  logic [7:0] seg2,
    input  logic       blink,
    output logic [3:0] an,
    output logic [6:0] cat,
    output logic       frame_start
);

    localparam int DWELL = CLK_HZ / DIGIT_HZ;
    localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int BL_W  = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [DW_W-1:0] DEAD_END   = DW_W'(DEAD_CYC);
    localparam logic [BL_W-1:0] HALF_LAST  = BL_W'(HALF - 1);
    localparam bit              LZ_ON      = (LZ_SUPPRESS != 0);

    // A dwell must fit the dead window plus at least two lit cycles
    if (DWELL < DEAD_CYC + 2) begin : g_dwell_check
        $error("seg7_scan_driver: DWELL (%0d) must be at least DEAD_CYC+2 (%0d)",
               DWELL, DEAD_CYC + 2);
    end

    logic [DW_W-1:0] dwell;
    digit_t          idx;
    logic [BL_W-1:0] blink_cnt;
    logic            phase;
    logic [7:0]      shadow1;
    logic [7:0]      shadow2;

    logic            frame_latch;
    logic            lit;
    logic [3:0]      nibble;
    logic            suppress;
    logic [6:0]      glyph;
    logic [3:0]      an_next;
    logic [6:0]      cat_next;

    assign frame_latch = (dwell == '0) && (idx == 2'd0);
    assign lit         = (dwell >= DEAD_END);

    // Dwell counter and digit index: advance to the next digit on dwell wrap
    always_ff @(posedge clk) begin
        if (!rst) begin
            dwell <= '0;
            idx   <= 2'd0;
        end else if (dwell == DWELL_LAST) begin
            dwell <= '0;
            idx   <= digit_t'(idx + 2'd1);
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    // Free-running blink timer; the visible phase toggles every half period
    always_ff @(posedge clk) begin
        if (!rst) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == HALF_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Frame-coherent shadow copy of both inputs, captured at the start of digit 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow1 <= 8'hFF;
            shadow2 <= 8'hFF;
        end else if (frame_latch) begin
            shadow1 <= seg1;
            shadow2 <= seg2;
        end
    end

    // Select the nibble for the current digit; odd positions are tens digits
    always_comb begin
        nibble = 4'hF;
        case (idx)
            2'd0:    nibble = shadow1[3:0];
            2'd1:    nibble = shadow1[7:4];
            2'd2:    nibble = shadow2[3:0];
            default: nibble = shadow2[7:4];
        endcase
        suppress = LZ_ON && idx[0] && (nibble == 4'h0);
    end

    seg7_decode u_decode (
        .nibble   (nibble),
        .suppress (suppress),
        .cat      (glyph)
    );

    // Next output values: dark during the dead window, blink masks segments only
    always_comb begin
        an_next  = AN_OFF;
        cat_next = SEG_BLANK;
        if (lit) begin
            an_next = an_select(idx);
            if (!(blink && !phase)) begin
                cat_next = glyph;
            end
        end
    end

    // Registered outputs, one cycle behind the internal state
    always_ff @(posedge clk) begin
        if (!rst) begin
            an          <= AN_OFF;
            cat         <= SEG_BLANK;
            frame_start <= 1'b0;
        end else begin
            an          <= an_next;
            cat         <= cat_next;
            frame_start <= frame_latch;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 10-cycle dwell, 2 dead cycles
// and a 20-cycle blink half period.
module tb_seg7_scan_driver;

    logic       clk;
    logic       rst;
    logic [7:0] seg1;
    logic [7:0] seg2;
    logic       blink;
    logic [3:0] an;
    logic [6:0] cat;
    logic       frame_start;

    int tests;
    int fails;

    typedef struct packed {
        logic [7:0] s1;
        logic [7:0] s2;
        logic [1:0] digit;
        logic [3:0] an;
        logic [6:0] cat;
    } vec_t;

    localparam int NVEC = 18;
    vec_t       vecs [NVEC];
    logic [6:0] glyph [4];

    seg7_scan_driver #(
        .CLK_HZ      (1000),
        .DIGIT_HZ    (100),
        .DEAD_CYC    (2),
        .BLINK_HZ    (25),
        .LZ_SUPPRESS (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg1        (seg1),
        .seg2        (seg2),
        .blink       (blink),
        .an          (an),
        .cat         (cat),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge where frame_start is seen high
    task automatic wait_frame(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s: frame_start not seen within 60 cycles", name);
        end
    endtask

    // Checks every cycle after a reset release against the scan schedule
    task automatic run_window(input int ncyc, input bit blinking, input string tag);
        int bad_an, bad_cat, bad_fs, bad_hot;
        bad_an = 0; bad_cat = 0; bad_fs = 0; bad_hot = 0;
        for (int n = 1; n <= ncyc; n++) begin
            int s, dw, ix;
            bit on, vis;
            logic [3:0] ea;
            logic [6:0] ec;
            logic ef;
            @(negedge clk);
            s   = n - 1;
            dw  = s % 10;
            ix  = (s / 10) % 4;
            on  = (dw >= 2);
            vis = ((s / 20) % 2) == 0;
            ea  = on ? ~(4'b0001 << ix) : 4'b1111;
            ec  = (on && !(blinking && !vis)) ? glyph[ix] : 7'b1111111;
            ef  = ((s % 40) == 0);
            if (an !== ea) bad_an++;
            if (cat !== ec) bad_cat++;
            if (frame_start !== ef) bad_fs++;
            if ($countones(~an) > 1) bad_hot++;
        end
        check({tag, "_an_bad_cycles"}, 32'(bad_an), 32'd0);
        check({tag, "_cat_bad_cycles"}, 32'(bad_cat), 32'd0);
        check({tag, "_fs_bad_cycles"}, 32'(bad_fs), 32'd0);
        check({tag, "_onehot_bad_cycles"}, 32'(bad_hot), 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;

        vecs[0]  = '{8'h07, 8'h10, 2'd0, 4'b1110, 7'b1111000};
        vecs[1]  = '{8'h07, 8'h10, 2'd1, 4'b1101, 7'b1111111};
        vecs[2]  = '{8'h07, 8'h10, 2'd2, 4'b1011, 7'b1000000};
        vecs[3]  = '{8'h07, 8'h10, 2'd3, 4'b0111, 7'b1111001};
        vecs[4]  = '{8'hAA, 8'h88, 2'd0, 4'b1110, 7'b0111111};
        vecs[5]  = '{8'hAA, 8'h88, 2'd1, 4'b1101, 7'b0111111};
        vecs[6]  = '{8'hAA, 8'h88, 2'd2, 4'b1011, 7'b0000000};
        vecs[7]  = '{8'hAA, 8'h88, 2'd3, 4'b0111, 7'b0000000};
        vecs[8]  = '{8'h39, 8'h42, 2'd0, 4'b1110, 7'b0010000};
        vecs[9]  = '{8'h39, 8'h42, 2'd1, 4'b1101, 7'b0110000};
        vecs[10] = '{8'h39, 8'h42, 2'd2, 4'b1011, 7'b0100100};
        vecs[11] = '{8'h39, 8'h42, 2'd3, 4'b0111, 7'b0011001};
        vecs[12] = '{8'h1B, 8'h6F, 2'd0, 4'b1110, 7'b1111111};
        vecs[13] = '{8'h1B, 8'h6F, 2'd1, 4'b1101, 7'b1111001};
        vecs[14] = '{8'h1B, 8'h6F, 2'd3, 4'b0111, 7'b0000010};
        vecs[15] = '{8'h50, 8'h05, 2'd0, 4'b1110, 7'b1000000};
        vecs[16] = '{8'h50, 8'h05, 2'd1, 4'b1101, 7'b0010010};
        vecs[17] = '{8'h50, 8'h05, 2'd3, 4'b0111, 7'b1111111};

        glyph[0] = 7'b1111000;
        glyph[1] = 7'b1111111;
        glyph[2] = 7'b1000000;
        glyph[3] = 7'b1111001;

        // Reset held for 5 cycles, then a full two-frame schedule check
        rst   = 1'b0;
        blink = 1'b0;
        seg1  = 8'h07;
        seg2  = 8'h10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("reset%0d_an", i), 32'(an), 32'hF);
            check($sformatf("reset%0d_cat", i), 32'(cat), 32'h7F);
            check($sformatf("reset%0d_fs", i), 32'(frame_start), 32'd0);
        end
        rst = 1'b1;
        run_window(81, 1'b0, "post_reset");

        // Table-driven decode and leading-zero vectors
        for (int v = 0; v < NVEC; v++) begin
            seg1 = vecs[v].s1;
            seg2 = vecs[v].s2;
            @(negedge clk);
            wait_frame($sformatf("vec%0d_frame", v));
            skip(10 * int'(vecs[v].digit) + 5);
            check($sformatf("vec%0d_an", v), 32'(an), 32'(vecs[v].an));
            check($sformatf("vec%0d_cat", v), 32'(cat), 32'(vecs[v].cat));
        end

        // Inputs changed mid-frame must not appear until the next latch
        seg1 = 8'h07;
        seg2 = 8'h10;
        @(negedge clk);
        wait_frame("coh_frame1");
        skip(25);
        seg1 = 8'h06;
        seg2 = 8'h23;
        skip(3);
        check("coh_d2_old_an", 32'(an), 32'b1011);
        check("coh_d2_old_cat", 32'(cat), 32'b1000000);
        skip(7);
        check("coh_d3_old_cat", 32'(cat), 32'b1111001);
        wait_frame("coh_frame2");
        skip(5);
        check("coh_d0_new_cat", 32'(cat), 32'b0000010);
        skip(20);
        check("coh_d2_new_cat", 32'(cat), 32'b0110000);

        // Blink from a fresh reset so the blink phase is known
        seg1  = 8'h07;
        seg2  = 8'h10;
        blink = 1'b1;
        rst   = 1'b0;
        skip(3);
        rst = 1'b1;
        run_window(65, 1'b1, "blink");
        check("blink_hidden_an", 32'(an), 32'b1011);
        check("blink_hidden_cat", 32'(cat), 32'h7F);
        blink = 1'b0;
        @(negedge clk);
        check("blink_release_an", 32'(an), 32'b1011);
        check("blink_release_cat", 32'(cat), 32'b1000000);

        // Reset asserted during the lit part of digit 3
        wait_frame("midrst_frame");
        skip(35);
        check("midrst_pre_an", 32'(an), 32'b0111);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_cat", 32'(cat), 32'h7F);
        check("midrst_fs", 32'(frame_start), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rel1_an", 32'(an), 32'hF);
        check("midrst_rel1_fs", 32'(frame_start), 32'd1);
        @(negedge clk);
        check("midrst_rel2_an", 32'(an), 32'hF);
        check("midrst_rel2_fs", 32'(frame_start), 32'd0);
        @(negedge clk);
        check("midrst_rel3_an", 32'(an), 32'b1110);
        check("midrst_rel3_cat", 32'(cat), 32'b1111000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
